// File: rtl/bram_multibank.sv
// Multi-bank tile buffer: NUM_BANKS rotating banks filled and drained in round-robin order.
// Optional BRAM_MULTIBANK_OUTREG_EN adds a read output register (read latency 2 instead of 1).
module bram_multibank #(
    parameter  int DATA_W    = 32,
    parameter  int ADDR_W    = 10,
    parameter  int NUM_BANKS = 2,
    localparam int BANK_W    = $clog2(NUM_BANKS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fill_req,
    output logic              fill_busy,
    input  logic              fill_we,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [DATA_W-1:0] fill_wdata,
    input  logic              fill_last,
    output logic              fill_done,
    output logic [BANK_W-1:0] fill_bank,
    input  logic              consume_req,
    output logic              consume_busy,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_rdata,
    output logic              rd_valid,
    input  logic              consume_last,
    output logic              consume_done,
    output logic [BANK_W-1:0] consume_bank,
    output logic [BANK_W:0]   full_cnt
);

    typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL, B_READING} bank_st_t;
    typedef enum logic {F_IDLE, F_ACTIVE} fill_st_t;
    typedef enum logic {C_IDLE, C_ACTIVE} cons_st_t;

    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

    bank_st_t          bank_st [NUM_BANKS];
    fill_st_t          f_st;
    cons_st_t          c_st;
    logic [BANK_W-1:0] wr_ptr;
    logic [BANK_W-1:0] rd_ptr;
    logic [BANK_W:0]   full_cnt_c;

    logic [DATA_W-1:0] mem [0:(NUM_BANKS << ADDR_W)-1];
    logic [DATA_W-1:0] rdata_p0;
    logic              vld_p0;
    logic              wr_hit;
    logic              rd_hit;

    function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
        return (b == LAST_BANK) ? '0 : b + BANK_W'(1);
    endfunction

    assign fill_busy    = (f_st == F_ACTIVE);
    assign consume_busy = (c_st == C_ACTIVE);
    assign fill_bank    = wr_ptr;
    assign consume_bank = rd_ptr;
    assign wr_hit       = fill_busy && fill_we;
    assign rd_hit       = consume_busy && rd_en;

    // Both FSMs update bank_st, but always on different banks: the fill side only
    // touches the FREE/FILLING bank at wr_ptr, the consume side the FULL/READING one.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) bank_st[b] <= B_FREE;
            f_st         <= F_IDLE;
            c_st         <= C_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill_done    <= 1'b0;
            consume_done <= 1'b0;
        end else begin
            fill_done    <= 1'b0;
            consume_done <= 1'b0;
            case (f_st)
                F_IDLE: begin
                    if (fill_req && bank_st[wr_ptr] == B_FREE) begin
                        bank_st[wr_ptr] <= B_FILLING;
                        f_st            <= F_ACTIVE;
                    end
                end
                F_ACTIVE: begin
                    if (fill_last) begin
                        bank_st[wr_ptr] <= B_FULL;
                        wr_ptr          <= next_bank(wr_ptr);
                        fill_done       <= 1'b1;
                        f_st            <= F_IDLE;
                    end
                end
                default: f_st <= F_IDLE;
            endcase
            case (c_st)
                C_IDLE: begin
                    if (consume_req && bank_st[rd_ptr] == B_FULL) begin
                        bank_st[rd_ptr] <= B_READING;
                        c_st            <= C_ACTIVE;
                    end
                end
                C_ACTIVE: begin
                    if (consume_last) begin
                        bank_st[rd_ptr] <= B_FREE;
                        rd_ptr          <= next_bank(rd_ptr);
                        consume_done    <= 1'b1;
                        c_st            <= C_IDLE;
                    end
                end
                default: c_st <= C_IDLE;
            endcase
        end
    end

    always_comb begin
        full_cnt_c = '0;
        for (int b = 0; b < NUM_BANKS; b++)
            if (bank_st[b] == B_FULL) full_cnt_c = full_cnt_c + (BANK_W+1)'(1);
    end
    assign full_cnt = full_cnt_c;

    // Storage: plain write port, no reset, so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (wr_hit) mem[{wr_ptr, fill_addr}] <= fill_wdata;
    end

    // Read stage p0: synchronous RAM read, data held while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0   <= 1'b0;
            rdata_p0 <= '0;
        end else begin
            vld_p0 <= rd_hit;
            if (rd_hit) rdata_p0 <= mem[{rd_ptr, rd_addr}];
        end
    end

`ifdef BRAM_MULTIBANK_OUTREG_EN
    logic [DATA_W-1:0] rdata_p1;
    logic              vld_p1;

    // Read stage p1: output register
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) rdata_p1 <= rdata_p0;
        end
    end

    assign rd_valid = vld_p1;
    assign rd_rdata = rdata_p1;
`else
    assign rd_valid = vld_p0;
    assign rd_rdata = rdata_p0;
`endif

endmodule

// File: tb/tb_bram_multibank.sv
// Directed bench for bram_multibank: 2-bank instance for round trip, reset, strobes, overlap
// and back-pressure; 3-bank instance for pointer wrap. Honours BRAM_MULTIBANK_OUTREG_EN.
module tb_bram_multibank;

`ifdef BRAM_MULTIBANK_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        fill_req, fill_busy, fill_we, fill_last, fill_done;
    logic [3:0]  fill_addr;
    logic [31:0] fill_wdata;
    logic [0:0]  fill_bank;
    logic        consume_req, consume_busy, rd_en, rd_valid, consume_last, consume_done;
    logic [3:0]  rd_addr;
    logic [31:0] rd_rdata;
    logic [0:0]  consume_bank;
    logic [1:0]  full_cnt;

    logic        t_fill_req, t_fill_busy, t_fill_we, t_fill_last, t_fill_done;
    logic [3:0]  t_fill_addr;
    logic [31:0] t_fill_wdata;
    logic [1:0]  t_fill_bank;
    logic        t_consume_req, t_consume_busy, t_rd_en, t_rd_valid, t_consume_last, t_consume_done;
    logic [3:0]  t_rd_addr;
    logic [31:0] t_rd_rdata;
    logic [1:0]  t_consume_bank;
    logic [2:0]  t_full_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [16];

    bram_multibank #(.DATA_W(32), .ADDR_W(4), .NUM_BANKS(2)) dut (
        .clk(clk), .rst(rst),
        .fill_req(fill_req), .fill_busy(fill_busy), .fill_we(fill_we), .fill_addr(fill_addr),
        .fill_wdata(fill_wdata), .fill_last(fill_last), .fill_done(fill_done), .fill_bank(fill_bank),
        .consume_req(consume_req), .consume_busy(consume_busy), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_rdata(rd_rdata), .rd_valid(rd_valid), .consume_last(consume_last),
        .consume_done(consume_done), .consume_bank(consume_bank), .full_cnt(full_cnt)
    );

    bram_multibank #(.DATA_W(32), .ADDR_W(4), .NUM_BANKS(3)) dut3 (
        .clk(clk), .rst(rst),
        .fill_req(t_fill_req), .fill_busy(t_fill_busy), .fill_we(t_fill_we), .fill_addr(t_fill_addr),
        .fill_wdata(t_fill_wdata), .fill_last(t_fill_last), .fill_done(t_fill_done),
        .fill_bank(t_fill_bank), .consume_req(t_consume_req), .consume_busy(t_consume_busy),
        .rd_en(t_rd_en), .rd_addr(t_rd_addr), .rd_rdata(t_rd_rdata), .rd_valid(t_rd_valid),
        .consume_last(t_consume_last), .consume_done(t_consume_done),
        .consume_bank(t_consume_bank), .full_cnt(t_full_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic grant_fill(input int exp_bank);
        fill_req = 1'b1;
        step();
        fill_req = 1'b0;
        chk("fill_grant_busy", 32'(fill_busy), 32'd1);
        chk("fill_grant_bank", 32'(fill_bank), 32'(exp_bank));
    endtask

    task automatic grant_consume(input int exp_bank);
        consume_req = 1'b1;
        step();
        consume_req = 1'b0;
        chk("consume_grant_busy", 32'(consume_busy), 32'd1);
        chk("consume_grant_bank", 32'(consume_bank), 32'(exp_bank));
    endtask

    task automatic fill_words(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fill_we    = 1'b1;
            fill_addr  = 4'(i);
            fill_wdata = base + 32'(i);
            fill_last  = (i == n - 1);
            step();
        end
        fill_we   = 1'b0;
        fill_last = 1'b0;
        chk("fill_done_on_commit", 32'(fill_done), 32'd1);
    endtask

    task automatic read_words(input int n, input bit do_release);
        for (int c = 0; c < n + LAT - 1; c++) begin
            rd_en        = (c < n);
            rd_addr      = 4'(c);
            consume_last = do_release && (c == n - 1);
            step();
            rd_en        = 1'b0;
            consume_last = 1'b0;
            if (do_release && c == n - 1) chk("consume_done_on_release", 32'(consume_done), 32'd1);
            if (c >= LAT - 1) begin
                chk("rd_valid", 32'(rd_valid), 32'd1);
                chk($sformatf("rd_data[%0d]", c - LAT + 1), rd_rdata, exp_q[c - LAT + 1]);
            end
        end
        step();
        chk("rd_valid_idle", 32'(rd_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        fill_req = 0; fill_we = 0; fill_addr = '0; fill_wdata = '0; fill_last = 0;
        consume_req = 0; rd_en = 0; rd_addr = '0; consume_last = 0;
        t_fill_req = 0; t_fill_we = 0; t_fill_addr = '0; t_fill_wdata = '0; t_fill_last = 0;
        t_consume_req = 0; t_rd_en = 0; t_rd_addr = '0; t_consume_last = 0;
        repeat (3) step();

        chk("rst_fill_busy", 32'(fill_busy), 32'd0);
        chk("rst_consume_busy", 32'(consume_busy), 32'd0);
        chk("rst_fill_done", 32'(fill_done), 32'd0);
        chk("rst_consume_done", 32'(consume_done), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_rdata", rd_rdata, 32'd0);
        chk("rst_full_cnt", 32'(full_cnt), 32'd0);
        chk("rst_fill_bank", 32'(fill_bank), 32'd0);
        chk("rst_consume_bank", 32'(consume_bank), 32'd0);
        rst = 1'b0;
        step();

        // single bank round trip
        grant_fill(0);
        chk("rt_full_cnt_filling", 32'(full_cnt), 32'd0);
        fill_words(32'hA000, 16);
        chk("rt_fill_busy_after", 32'(fill_busy), 32'd0);
        chk("rt_full_cnt_1", 32'(full_cnt), 32'd1);
        chk("rt_fill_bank_adv", 32'(fill_bank), 32'd1);
        step();
        chk("rt_fill_done_pulse", 32'(fill_done), 32'd0);
        grant_consume(0);
        for (int i = 0; i < 16; i++) exp_q[i] = 32'hA000 + 32'(i);
        read_words(16, 1'b1);
        chk("rt_consume_done_pulse", 32'(consume_done), 32'd0);
        chk("rt_full_cnt_0", 32'(full_cnt), 32'd0);
        chk("rt_consume_bank_adv", 32'(consume_bank), 32'd1);
        chk("rt_consume_busy_after", 32'(consume_busy), 32'd0);

        // reset in the middle of a fill
        grant_fill(1);
        for (int i = 0; i < 5; i++) begin
            fill_we    = 1'b1;
            fill_addr  = 4'(i);
            fill_wdata = 32'hE000 + 32'(i);
            rst        = (i == 4);
            step();
        end
        fill_we = 1'b0;
        chk("mid_rst_fill_busy", 32'(fill_busy), 32'd0);
        chk("mid_rst_fill_bank", 32'(fill_bank), 32'd0);
        chk("mid_rst_consume_bank", 32'(consume_bank), 32'd0);
        chk("mid_rst_full_cnt", 32'(full_cnt), 32'd0);
        chk("mid_rst_rd_rdata", rd_rdata, 32'd0);
        rst = 1'b0;

        // strobes while not busy must do nothing (bank0 addr15 keeps 0xA00F)
        fill_we = 1'b1; fill_addr = 4'd15; fill_wdata = 32'hDEADBEEF; fill_last = 1'b1;
        rd_en = 1'b1; rd_addr = 4'd0; consume_last = 1'b1;
        step();
        fill_we = 1'b0; fill_last = 1'b0; rd_en = 1'b0; consume_last = 1'b0;
        chk("ign_rd_valid_a", 32'(rd_valid), 32'd0);
        chk("ign_fill_done", 32'(fill_done), 32'd0);
        chk("ign_consume_done", 32'(consume_done), 32'd0);
        step();
        chk("ign_rd_valid_b", 32'(rd_valid), 32'd0);
        chk("ign_fill_bank", 32'(fill_bank), 32'd0);
        chk("ign_full_cnt", 32'(full_cnt), 32'd0);

        // overlap: fill bank0 (addr 0..14), then consume bank0 while filling bank1
        grant_fill(0);
        fill_words(32'hC000, 15);
        chk("ovl_fill_bank_1", 32'(fill_bank), 32'd1);
        chk("ovl_full_cnt_1", 32'(full_cnt), 32'd1);
        fill_req = 1'b1; consume_req = 1'b1;
        step();
        fill_req = 1'b0; consume_req = 1'b0;
        chk("ovl_both_busy_f", 32'(fill_busy), 32'd1);
        chk("ovl_both_busy_c", 32'(consume_busy), 32'd1);
        chk("ovl_full_cnt_0", 32'(full_cnt), 32'd0);
        for (int i = 0; i < 15; i++) exp_q[i] = 32'hC000 + 32'(i);
        exp_q[15] = 32'hA00F;
        for (int c = 0; c < 16 + LAT - 1; c++) begin
            if (c < 16) begin
                fill_we = 1'b1; fill_addr = 4'(c); fill_wdata = 32'hD000 + 32'(c);
                fill_last = (c == 15);
                rd_en = 1'b1; rd_addr = 4'(c); consume_last = (c == 15);
            end
            step();
            fill_we = 1'b0; fill_last = 1'b0; rd_en = 1'b0; consume_last = 1'b0;
            if (c == 7) chk("ovl_fill_bank_mid", 32'(fill_bank), 32'd1);
            if (c == 15) begin
                chk("ovl_fill_done", 32'(fill_done), 32'd1);
                chk("ovl_consume_done", 32'(consume_done), 32'd1);
                chk("ovl_full_cnt_net", 32'(full_cnt), 32'd1);
                chk("ovl_consume_bank_adv", 32'(consume_bank), 32'd1);
                chk("ovl_fill_bank_wrap", 32'(fill_bank), 32'd0);
            end
            if (c >= LAT - 1) begin
                chk("ovl_rd_valid", 32'(rd_valid), 32'd1);
                chk($sformatf("ovl_rd_data[%0d]", c - LAT + 1), rd_rdata, exp_q[c - LAT + 1]);
            end
        end
        step();
        grant_consume(1);
        for (int i = 0; i < 16; i++) exp_q[i] = 32'hD000 + 32'(i);
        read_words(16, 1'b1);

        // back-pressure from a clean start
        rst = 1'b1;
        step();
        rst = 1'b0;
        grant_fill(0);
        fill_words(32'h5000, 16);
        grant_fill(1);
        fill_words(32'h6000, 16);
        chk("bp_full_cnt_2", 32'(full_cnt), 32'd2);
        fill_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("bp_fill_busy_stall", 32'(fill_busy), 32'd0);
            chk("bp_full_cnt_hold", 32'(full_cnt), 32'd2);
        end
        grant_consume(0);
        for (int i = 0; i < 16; i++) exp_q[i] = 32'h5000 + 32'(i);
        read_words(16, 1'b0);
        chk("bp_still_stalled", 32'(fill_busy), 32'd0);
        consume_last = 1'b1;
        step();
        consume_last = 1'b0;
        chk("bp_release_done", 32'(consume_done), 32'd1);
        chk("bp_no_same_cycle_grant", 32'(fill_busy), 32'd0);
        chk("bp_full_cnt_after_rel", 32'(full_cnt), 32'd1);
        step();
        fill_req = 1'b0;
        chk("bp_regrant_busy", 32'(fill_busy), 32'd1);
        chk("bp_regrant_bank", 32'(fill_bank), 32'd0);
        fill_last = 1'b1;
        step();
        fill_last = 1'b0;
        grant_consume(1);
        for (int i = 0; i < 16; i++) exp_q[i] = 32'h6000 + 32'(i);
        read_words(16, 1'b1);

        // pointer wrap on the 3-bank instance, data tagged with round number
        for (int r = 0; r < 7; r++) begin
            t_fill_req = 1'b1;
            step();
            t_fill_req = 1'b0;
            chk("wrap_fill_busy", 32'(t_fill_busy), 32'd1);
            chk($sformatf("wrap_fill_bank_r%0d", r), 32'(t_fill_bank), 32'(r % 3));
            for (int i = 0; i < 4; i++) begin
                t_fill_we = 1'b1; t_fill_addr = 4'(i);
                t_fill_wdata = (32'(r) << 16) | 32'(i);
                t_fill_last = (i == 3);
                step();
            end
            t_fill_we = 1'b0; t_fill_last = 1'b0;
            t_consume_req = 1'b1;
            step();
            t_consume_req = 1'b0;
            chk($sformatf("wrap_consume_bank_r%0d", r), 32'(t_consume_bank), 32'(r % 3));
            for (int c = 0; c < 4 + LAT - 1; c++) begin
                t_rd_en = (c < 4); t_rd_addr = 4'(c); t_consume_last = (c == 3);
                step();
                t_rd_en = 1'b0; t_consume_last = 1'b0;
                if (c >= LAT - 1) begin
                    chk("wrap_rd_valid", 32'(t_rd_valid), 32'd1);
                    chk($sformatf("wrap_rd_data_r%0d", r), t_rd_rdata,
                        (32'(r) << 16) | 32'(c - LAT + 1));
                end
            end
            step();
        end
        chk("wrap_full_cnt_end", 32'(t_full_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_multibank.md
Name: bram_multibank

Overview:
- Parametrised successor to the two-bank ping-pong tile buffer: real storage, NUM_BANKS rotating banks, per-bank ownership tracking.
- Sits between the loader/DMA-read path (fill side) and the systolic-array feeder (consume side).
- Writer fills banks in round-robin order. Reader drains full banks in the same order.
- Fill and consume overlap whenever at least one bank is free and one is full.

Parameters:
- DATA_W, AXI_DATA_WIDTH: word width in bits.
- ADDR_W, 10: per-bank depth = 2^ADDR_W words.
- NUM_BANKS, 2: bank count, >=2; non-power-of-2 legal.
- BANK_W, $clog2(NUM_BANKS): bank index width (derived, localparam).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- fill_req  in  1  level; request ownership of next fill bank.
- fill_busy  out  1  fill side owns a bank.
- fill_we  in  1  write strobe; honoured only while fill_busy.
- fill_addr  in  ADDR_W  word address within owned bank.
- fill_wdata  in  DATA_W  write data.
- fill_last  in  1  commit owned bank (same-cycle fill_we still written).
- fill_done  out  1  one-cycle pulse on commit.
- fill_bank  out  BANK_W  bank being / next to be filled.
- consume_req  in  1  level; request ownership of next full bank.
- consume_busy  out  1  consume side owns a bank.
- rd_en  in  1  read strobe; honoured only while consume_busy.
- rd_addr  in  ADDR_W  word address within owned bank.
- rd_rdata  out  DATA_W  read data.
- rd_valid  out  1  rd_rdata valid this cycle.
- consume_last  in  1  release owned bank.
- consume_done  out  1  one-cycle pulse on release.
- consume_bank  out  BANK_W  bank being / next to be consumed.
- full_cnt  out  BANK_W+1  banks in FULL state.

Behaviour:
- Storage:
  - NUM_BANKS*2^ADDR_W words, simple dual-port, inferred BRAM.
  - Physical address = {bank, addr}.
  - Contents undefined after reset; never cleared.
- Per-bank state: FREE, FILLING, FULL, READING. Transitions:
  - FREE->FILLING on fill grant; FILLING->FULL on fill_last.
  - FULL->READING on consume grant; READING->FREE on consume_last.
- Pointers:
  - wr_ptr and rd_ptr wrap NUM_BANKS-1 -> 0.
  - fill_bank = wr_ptr; consume_bank = rd_ptr.
- Fill FSM (F_IDLE, F_ACTIVE):
  - Grant: F_IDLE with fill_req=1 and state[wr_ptr]==FREE -> F_ACTIVE; fill_busy=1 from the next cycle.
  - No free bank: remain idle, fill_busy=0, request held.
  - Commit: fill_last in F_ACTIVE -> bank FULL, wr_ptr+1, fill_done pulse next cycle, F_IDLE.
  - Earliest regrant is the cycle after the commit.
- Consume FSM (C_IDLE, C_ACTIVE): mirror of the fill FSM.
  - Grant condition is state[rd_ptr]==FULL.
  - Release: consume_last -> bank FREE, rd_ptr+1, consume_done pulse.
- Read path:
  - Latency 1: rd_en at cycle N -> rd_valid=1, rd_rdata at N+1.
  - rd_rdata holds its last value when rd_valid=0.
  - rd_en together with consume_last: read still performed.
- Ignored strobes: fill_we, fill_last, rd_en, consume_last while the matching busy=0 have no effect.
- Simultaneous events:
  - Commit and release on different banks in the same cycle are both applied; full_cnt changes by the net amount.
  - Grant decisions use registered bank state: a bank committed in cycle N is grantable to the reader at N+1 at the earliest. The same holds for release -> fill.
- Full/empty boundaries:
  - All banks FULL: fill stalls.
  - full_cnt==0 with no FILLING bank: consume stalls.
- Reset (also mid-operation):
  - All banks FREE; pointers 0; both FSMs idle.
  - All outputs 0: busy, done, rd_valid, rd_rdata, full_cnt, fill_bank, consume_bank.

Optional Feature:
- Macro: BRAM_MULTIBANK_OUTREG_EN.
- Defined: extra output register on the read path; read latency 2 (rd_en at N -> rd_valid/rd_rdata at N+2). Reset clears the register.
- Undefined: latency 1 as above.
- Bank FSMs are identical in both builds.
- consume_last releases the bank immediately; reads already in flight still return data.

Test Plan (NUM_BANKS=2, ADDR_W=4, DATA_W=32 unless stated):
- Single bank round trip:
  - Stimulus: fill_req; write addr 0..15 = 0xA000+i; fill_last with last write; then consume_req; rd_en on 0..15; consume_last.
  - Expected: rd_rdata = 0xA000+i, one cycle after each rd_en; fill_done and consume_done each pulse once; full_cnt goes 0->1->0.
- Overlap:
  - Stimulus: fill bank0; consume bank0 while filling bank1.
  - Expected: fill_bank=1 during overlap; no data corruption; consume_bank advances to 1 after release.
- Back-pressure: fill both banks without consuming, then fill_req held for 10 cycles.
  - Expected: fill_busy=0 and full_cnt=2 throughout.
  - On consume_last of bank0: fill granted next cycle with fill_bank=0.
- Wrap, NUM_BANKS=3: 7 fill/consume rounds.
  - Expected: bank order 0,1,2,0,1,2,0; data tagged with round number reads back correctly.
- Reset mid-fill: rst at 5th write.
  - Expected: all outputs 0 next cycle; full_cnt=0; a fresh fill_req is granted bank 0.
- Ignored strobes: fill_we/rd_en while not busy.
  - Expected: no memory change (verified by later readback); rd_valid stays 0.
  - With BRAM_MULTIBANK_OUTREG_EN: repeat round trip; expect rd_valid at N+2.
